mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Request sequencer directly upstream of the 8-bit data Memory.
//  Accepts read and write requests from the datapath/control unit over a valid/ready handshake.
//  Drives Address, WriteData, MemReadEn and MemWriteEn, never asserting both enables together.
//  Captures the memory's registered ReadData and supports read bursts of 1-4 sequential beats.
// PARAMETERS
//  ADDR_W   8  address width; addresses wrap modulo 2**ADDR_W
//  DATA_W   8  data width
//  BURST_W  2  burst-length field width; beats = burst_len+1 (1..4)
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        reset: asynchronous, active-low
//  req_valid   in   1        request present
//  req_ready   out  1        controller can accept a request (high only in IDLE)
//  req_write   in   1        1 = write, 0 = read
//  req_addr    in   ADDR_W   start address
//  req_wdata   in   DATA_W   write data
//  burst_len   in   BURST_W  read beats minus 1; ignored for writes
//  resp_valid  out  1        one-cycle pulse per read beat; no backpressure
//  resp_data   out  DATA_W   read beat data; valid only while resp_valid=1
//  wr_done     out  1        one-cycle pulse after a write is issued
//  busy        out  1        high in any state other than IDLE
//  Address     out  ADDR_W   to Memory
//  WriteData   out  DATA_W   to Memory
//  MemReadEn   out  1        to Memory
//  MemWriteEn  out  1        to Memory
//  ReadData    in   DATA_W   from Memory; updated at the edge that samples MemReadEn=1
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=IDLE; every output is 0 except req_ready=1.
//   - Any outstanding burst or response in the capture pipe is discarded.
//  Memory-side outputs:
//   - Decoded from state and internal registers only; no combinational input-to-output path.
//   - Address and WriteData are 0 when neither enable is asserted.
//  FSM states: IDLE, RD, DRAIN, WR.
//   - IDLE: req_ready=1. A handshake (req_valid & req_ready at a clock edge) latches cur_addr=req_addr and wdata.
//     - Read: latches remaining=burst_len+1 and goes to RD.
//     - Write: goes to WR.
//   - RD: MemReadEn=1, Address=cur_addr.
//     - Each cycle: cur_addr <= cur_addr+1, with 8'hFF wrapping to 8'h00; remaining <= remaining-1.
//     - Goes to DRAIN when remaining==1.
//     - Beats issue back-to-back: one beat per cycle.
//   - DRAIN: no enables asserted. Waits one cycle for the last capture, then goes to IDLE.
//   - WR: MemWriteEn=1, Address=cur_addr, WriteData=wdata for exactly one cycle, then IDLE. wr_done pulses in the following cycle.
//  Read latency:
//   - A beat issued in cycle t has ReadData valid in t+1.
//   - resp_data is registered at the end of t+1; resp_valid is high in t+2.
//   - A 4-beat burst accepted at edge e0 produces resp_valid in cycles e0+2 .. e0+5.
//  Back-to-back requests:
//   - A new request may be accepted in IDLE while the last resp_valid of the previous burst is still pulsing.
//   - Responses are never reordered.
//  Handshake:
//   - req_valid held while req_ready=0 is ignored; the request is accepted on the first IDLE edge.
//  Writes: always single-beat; burst_len is ignored.
//  Write data: req_wdata is sampled only at the handshake edge.
//  Reset mid-burst: remaining beats are dropped; no resp_valid is produced after reset release.
// STRUCTURE
//  Package mem_ctrl_pkg:
//   - state encoding localparams S_IDLE, S_RD, S_DRAIN, S_WR (2-bit)
//   - ADDR_W, DATA_W, BURST_W defaults
//  Sub-module mem_resp_stage:
//   - 1-deep capture register: inputs issued_q and ReadData; outputs resp_valid and resp_data.
//   - Async active-low reset.
//  The top level holds the FSM, address/remaining counters and memory output decode.
// TESTING
//  - Reset: rst=0 mid-RD burst -> all outputs 0, req_ready=1; no resp_valid for 3 cycles after release.
//  - Single write: addr=8'h05, wdata=8'hA5 -> MemWriteEn=1 for 1 cycle with Address=5 and WriteData=A5, then wr_done pulse.
//  - Single read: memory[5]=A5, read addr=5, burst_len=0 -> MemReadEn for 1 cycle; resp_valid with resp_data=8'hA5 2 cycles after accept.
//  - Burst: read addr=8'hFE, burst_len=3 -> Addresses FE, FF, 00, 01 on consecutive cycles; 4 consecutive resp_valid pulses in order.
//  - Back-to-back: write then read on consecutive IDLE cycles -> read returns the newly written data; MemReadEn and MemWriteEn never both 1.
//  - Handshake hold: req_valid asserted during a burst -> accepted only on the first IDLE edge; busy stays 0 only while IDLE.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared widths and state encoding for the memory access controller
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int BURST_W_DEF = 2;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_RD    = 2'd1;
  localparam state_t S_DRAIN = 2'd2;
  localparam state_t S_WR    = 2'd3;

endpackage

// File: rtl/mem_resp_stage.sv
// rtl/mem_resp_stage.sv - one-deep capture of memory read data into the response port
module mem_resp_stage
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issued_q,
  input  logic [DATA_W-1:0] read_data,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data
);

  // capture ReadData in the cycle after a beat was issued; data is zeroed between beats
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      resp_valid <= issued_q;
      resp_data  <= issued_q ? read_data : '0;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - request sequencer driving the 8-bit data memory
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  input  logic [BURST_W-1:0] burst_len,
  output logic               resp_valid,
  output logic [DATA_W-1:0]  resp_data,
  output logic               wr_done,
  output logic               busy,
  output logic [ADDR_W-1:0]  Address,
  output logic [DATA_W-1:0]  WriteData,
  output logic               MemReadEn,
  output logic               MemWriteEn,
  input  logic [DATA_W-1:0]  ReadData
);

  localparam logic [BURST_W:0] REM_ONE = (BURST_W+1)'(1);

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  cur_addr;
  logic [DATA_W-1:0]  wdata_q;
  logic [BURST_W:0]   remaining;
  logic               issued_q;
  logic               wr_done_q;
  logic               accept;

  assign accept  = req_valid && (state == S_IDLE);
  assign wr_done = wr_done_q;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // next-state: reads run until the last beat, then one drain cycle for its capture
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid) state_nxt = req_write ? S_WR : S_RD;
      S_RD:    if (remaining == REM_ONE) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_IDLE;
      S_WR:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // request latch, address/beat counters, and one-cycle delayed issue flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_addr  <= '0;
      wdata_q   <= '0;
      remaining <= '0;
      issued_q  <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      if (accept) begin
        cur_addr  <= req_addr;
        wdata_q   <= req_wdata;
        remaining <= {1'b0, burst_len} + REM_ONE;
      end else if (state == S_RD) begin
        cur_addr  <= cur_addr + 1'b1;
        remaining <= remaining - REM_ONE;
      end
      issued_q  <= (state == S_RD);
      wr_done_q <= (state == S_WR);
    end
  end

  // output decode from state only; address and data are held at zero when memory is idle
  always_comb begin
    req_ready  = 1'b0;
    busy       = 1'b1;
    MemReadEn  = 1'b0;
    MemWriteEn = 1'b0;
    Address    = '0;
    WriteData  = '0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_RD: begin
        MemReadEn = 1'b1;
        Address   = cur_addr;
      end
      S_WR: begin
        MemWriteEn = 1'b1;
        Address    = cur_addr;
        WriteData  = wdata_q;
      end
      default: ;
    endcase
  end

  mem_resp_stage #(.DATA_W(DATA_W)) u_resp (
    .clk        (clk),
    .rst        (rst),
    .issued_q   (issued_q),
    .read_data  (ReadData),
    .resp_valid (resp_valid),
    .resp_data  (resp_data)
  );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic [1:0] burst_len = 2'd0;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       wr_done;
  logic       busy;
  logic [7:0] Address;
  logic [7:0] WriteData;
  logic       MemReadEn;
  logic       MemWriteEn;
  logic [7:0] ReadData = 8'h00;

  mem_access_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .burst_len  (burst_len),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .wr_done    (wr_done),
    .busy       (busy),
    .Address    (Address),
    .WriteData  (WriteData),
    .MemReadEn  (MemReadEn),
    .MemWriteEn (MemWriteEn),
    .ReadData   (ReadData)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // memory the DUT talks to
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (MemWriteEn) mem[Address] <= WriteData;
    if (MemReadEn)  ReadData <= mem[Address];
  end

  // reference model: shadow memory plus queues of expected events keyed by cycle
  typedef struct { int cyc; bit wr; logic [7:0] addr; logic [7:0] data; } op_t;
  typedef struct { int cyc; logic [7:0] data; } rsp_t;
  logic [7:0] model_mem [256];
  op_t        op_q[$];
  rsp_t       rsp_q[$];
  int         wd_q[$];
  logic [7:0] cap_q[$];
  int         wr_seen = 0;
  int         next_free = 0;

  logic       mon_ev;

  // per-cycle monitor, sampled 3 time units after the rising edge
  always @(posedge clk) begin
    #3;
    if (rst) begin
      chk("rd_wr_exclusive", {31'd0, MemReadEn & MemWriteEn}, 32'd0);
      mon_ev = (op_q.size() > 0) && (op_q[0].cyc == cyc);
      chk("mem_enables", {30'd0, MemWriteEn, MemReadEn},
          mon_ev ? (op_q[0].wr ? 32'd2 : 32'd1) : 32'd0);
      if (mon_ev) begin
        chk("mem_addr", {24'd0, Address}, {24'd0, op_q[0].addr});
        if (op_q[0].wr) chk("mem_wdata", {24'd0, WriteData}, {24'd0, op_q[0].data});
        void'(op_q.pop_front());
      end else begin
        chk("idle_addr", {24'd0, Address}, 32'd0);
        chk("idle_wdata", {24'd0, WriteData}, 32'd0);
      end
      mon_ev = (rsp_q.size() > 0) && (rsp_q[0].cyc == cyc);
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, mon_ev});
      if (mon_ev) begin
        chk("resp_data", {24'd0, resp_data}, {24'd0, rsp_q[0].data});
        void'(rsp_q.pop_front());
      end
      if (resp_valid) cap_q.push_back(resp_data);
      mon_ev = (wd_q.size() > 0) && (wd_q[0] == cyc);
      chk("wr_done", {31'd0, wr_done}, {31'd0, mon_ev});
      if (mon_ev) void'(wd_q.pop_front());
      if (wr_done) wr_seen++;
    end
  end

  // issue one request; the model predicts the accepting edge from earlier traffic
  task automatic send(input bit w, input logic [7:0] a, input logic [7:0] d, input logic [1:0] bl);
    int e;
    logic [7:0] ai;
    e = (cyc + 1 > next_free) ? cyc + 1 : next_free;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    burst_len = bl;
    while (cyc + 1 < e) begin
      chk("ready_while_busy", {31'd0, req_ready}, 32'd0);
      chk("busy_while_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    chk("ready_in_idle", {31'd0, req_ready}, 32'd1);
    chk("busy_in_idle", {31'd0, busy}, 32'd0);
    if (w) begin
      op_q.push_back('{e, 1'b1, a, d});
      wd_q.push_back(e + 1);
      model_mem[a] = d;
      next_free = e + 2;
    end else begin
      for (int i = 0; i <= int'(bl); i++) begin
        ai = a + i[7:0];
        op_q.push_back('{e + i, 1'b0, ai, 8'h00});
        rsp_q.push_back('{e + 2 + i, model_mem[ai]});
      end
      next_free = e + int'(bl) + 3;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = 8'($urandom);
    req_wdata = 8'($urandom);
    burst_len = 2'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_resp_data"}, {24'd0, resp_data}, 32'd0);
    chk({tag, "_wr_done"}, {31'd0, wr_done}, 32'd0);
    chk({tag, "_enables"}, {30'd0, MemWriteEn, MemReadEn}, 32'd0);
    chk({tag, "_addr"}, {24'd0, Address}, 32'd0);
    chk({tag, "_wdata"}, {24'd0, WriteData}, 32'd0);
  endtask

  typedef struct {
    bit             wr;
    logic [7:0]     addr;
    logic [7:0]     wdata;
    logic [1:0]     blen;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ws;
    for (int i = 0; i < 256; i++) begin
      mem[i]       = 8'(i) ^ 8'h3C;
      model_mem[i] = 8'(i) ^ 8'h3C;
    end
    // beat j of the expected data sits in byte j of exp
    tbl[0] = '{1'b1, 8'h05, 8'hA5, 2'd0, 32'h0};
    tbl[1] = '{1'b0, 8'h05, 8'h00, 2'd0, {8'h00, 8'h00, 8'h00, 8'hA5}};
    tbl[2] = '{1'b1, 8'hFE, 8'h11, 2'd3, 32'h0};
    tbl[3] = '{1'b1, 8'hFF, 8'h22, 2'd1, 32'h0};
    tbl[4] = '{1'b1, 8'h00, 8'h33, 2'd2, 32'h0};
    tbl[5] = '{1'b1, 8'h01, 8'h44, 2'd0, 32'h0};
    tbl[6] = '{1'b0, 8'hFE, 8'h00, 2'd3, {8'h44, 8'h33, 8'h22, 8'h11}};
    tbl[7] = '{1'b0, 8'hFF, 8'h00, 2'd1, {8'h00, 8'h00, 8'h33, 8'h22}};
    tbl[8] = '{1'b1, 8'h05, 8'h5C, 2'd3, 32'h0};
    tbl[9] = '{1'b0, 8'h04, 8'h00, 2'd2, {8'h00, 8'h3A, 8'h5C, 8'h38}};

    // power-on reset
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    next_free = cyc + 1;
    @(negedge clk);

    // table-driven directed requests
    for (int i = 0; i < 10; i++) begin
      cap_q.delete();
      ws = wr_seen;
      send(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].blen);
      repeat (7) @(negedge clk);
      if (tbl[i].wr) begin
        chk($sformatf("tbl%0d_wr_done_count", i), wr_seen - ws, 32'd1);
      end else begin
        chk($sformatf("tbl%0d_beats", i), cap_q.size(), int'(tbl[i].blen) + 1);
        for (int j = 0; j <= int'(tbl[i].blen); j++)
          chk($sformatf("tbl%0d_beat%0d", i, j), {24'd0, cap_q[j]}, {24'd0, tbl[i].exp[j]});
      end
    end

    // back-to-back write then read of the same address
    send(1'b1, 8'h80, 8'hC3, 2'd2);
    send(1'b0, 8'h80, 8'h00, 2'd0);
    repeat (4) @(negedge clk);

    // request held during a burst is taken on the first IDLE edge
    send(1'b0, 8'h10, 8'h00, 2'd3);
    send(1'b1, 8'h20, 8'h7E, 2'd0);
    send(1'b0, 8'h20, 8'h00, 2'd1);
    repeat (6) @(negedge clk);

    // reset in the middle of a read burst
    send(1'b0, 8'h30, 8'h00, 2'd3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("midburst");
    op_q.delete();
    rsp_q.delete();
    wd_q.delete();
    cap_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    next_free = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    end

    // randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(1'($urandom), 8'($urandom), 8'($urandom), 2'($urandom));
    end

    repeat (10) @(negedge clk);
    chk("op_q_drained", op_q.size(), 32'd0);
    chk("rsp_q_drained", rsp_q.size(), 32'd0);
    chk("wd_q_drained", wd_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
